pbch_llr_demapper: RTL and testbench



---
 rtl/pbch_llr_demapper.sv | 164 ++++++++++++++++
 tb/tb_pbch_llr_demapper.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbch_llr_demapper.sv
// PBCH LLR demapper: strips DMRS/SSS REs from SSB symbols 1..3 and emits
// saturated QPSK soft-bit pairs, framed per SSB with tlast on pair 432.
module pbch_llr_demapper #(
    parameter int unsigned IN_DW      = 32,
    parameter int unsigned LLR_DW     = 8,
    parameter int unsigned LLR_SHIFT  = 8,
    parameter int unsigned SC_PER_SYM = 240
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [9:0]            N_id_i,
    input  logic                  N_id_valid_i,
    input  logic                  PBCH_start_i,
    input  logic [IN_DW-1:0]      s_axis_in_tdata,
    input  logic                  s_axis_in_tvalid,
    output logic [2*LLR_DW-1:0]   m_axis_llr_tdata,
    output logic                  m_axis_llr_tvalid,
    output logic                  m_axis_llr_tlast,
    output logic                  dmrs_valid_o,
    output logic                  abort_o
);

    localparam int unsigned CW            = IN_DW / 2;
    localparam int unsigned SCW           = $clog2(SC_PER_SYM);
    localparam int unsigned PAIRS_PER_SSB = 432;
    localparam int unsigned CNTW          = $clog2(PAIRS_PER_SSB);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYM1 = 2'd1;
    localparam logic [1:0] ST_SYM2 = 2'd2;
    localparam logic [1:0] ST_SYM3 = 2'd3;

    // SSS plus guard band occupies subcarriers 48..191 of symbol 2
    localparam logic [SCW-1:0]  SSS_FIRST = SCW'(48);
    localparam logic [SCW-1:0]  SSS_LAST  = SCW'(191);
    localparam logic [SCW-1:0]  LAST_SC   = SCW'(SC_PER_SYM - 1);
    localparam logic [CNTW-1:0] LAST_PAIR = CNTW'(PAIRS_PER_SSB - 1);

    // Symmetric saturation limits; the most negative code is never produced
    localparam logic signed [CW-1:0] POS_LIM = CW'((2 ** (LLR_DW - 1)) - 1);
    localparam logic signed [CW-1:0] NEG_LIM = -POS_LIM;

    // Shift then clamp one component to a symmetric LLR
    function automatic logic [LLR_DW-1:0] sat_llr(input logic signed [CW-1:0] x);
        logic signed [CW-1:0] sh;
        sh = x >>> LLR_SHIFT;
        if (sh > POS_LIM)      sat_llr = LLR_DW'(POS_LIM);
        else if (sh < NEG_LIM) sat_llr = LLR_DW'(NEG_LIM);
        else                   sat_llr = LLR_DW'(sh);
    endfunction

    logic [1:0]          state_q, state_d;
    logic [SCW-1:0]      sc_cnt_q, sc_cnt_d;
    logic [1:0]          ssb_v_q, ssb_v_d;
    logic [1:0]          v_q;
    logic                id_ok_q;
    logic [CNTW-1:0]     llr_cnt_q;
    logic                s1_data_q;
    logic                s1_dmrs_q;
    logic [2*LLR_DW-1:0] s1_llr_q;

    logic                start_go;
    logic                abort_c;
    logic [1:0]          cur_sym;
    logic [SCW-1:0]      cur_k;
    logic [1:0]          cur_v;
    logic                beat_acc;
    logic                in_sss;
    logic                is_dmrs;
    logic                is_data;
    logic                unused_nid;

    assign unused_nid = ^N_id_i[9:2];

    // Next-state: a start (also as abort) makes the current beat SYM1 sc 0
    always_comb begin
        start_go = PBCH_start_i && id_ok_q;
        abort_c  = start_go && (state_q != ST_IDLE);
        cur_sym  = start_go ? ST_SYM1 : state_q;
        cur_k    = start_go ? '0 : sc_cnt_q;
        cur_v    = start_go ? v_q : ssb_v_q;
        beat_acc = s_axis_in_tvalid && (cur_sym != ST_IDLE);
        in_sss   = (cur_sym == ST_SYM2) && (cur_k >= SSS_FIRST) && (cur_k <= SSS_LAST);
        is_dmrs  = !in_sss && (cur_k[1:0] == cur_v);
        is_data  = !in_sss && !is_dmrs;
        state_d  = cur_sym;
        sc_cnt_d = cur_k;
        ssb_v_d  = cur_v;
        if (beat_acc) begin
            if (cur_k == LAST_SC) begin
                sc_cnt_d = '0;
                state_d  = (cur_sym == ST_SYM3) ? ST_IDLE : 2'(cur_sym + 2'd1);
            end else begin
                sc_cnt_d = SCW'(cur_k + 1'b1);
            end
        end
    end

    // State, subcarrier counter and per-SSB DMRS shift
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            sc_cnt_q <= '0;
            ssb_v_q  <= '0;
        end else begin
            state_q  <= state_d;
            sc_cnt_q <= sc_cnt_d;
            ssb_v_q  <= ssb_v_d;
        end
    end

    // Cell-ID latch; consumed at the next PBCH start
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q     <= '0;
            id_ok_q <= 1'b0;
        end else if (N_id_valid_i) begin
            v_q     <= N_id_i[1:0];
            id_ok_q <= 1'b1;
        end
    end

    // Stage 1: classify the beat and compute saturated LLRs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_data_q <= 1'b0;
            s1_dmrs_q <= 1'b0;
            s1_llr_q  <= '0;
        end else begin
            s1_data_q <= beat_acc && is_data;
            s1_dmrs_q <= beat_acc && is_dmrs;
            s1_llr_q  <= {sat_llr(s_axis_in_tdata[IN_DW-1:CW]), sat_llr(s_axis_in_tdata[CW-1:0])};
        end
    end

    // Stage 2: registered outputs, pair counting and tlast; abort flushes stage 1
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_axis_llr_tdata  <= '0;
            m_axis_llr_tvalid <= 1'b0;
            m_axis_llr_tlast  <= 1'b0;
            dmrs_valid_o      <= 1'b0;
            abort_o           <= 1'b0;
            llr_cnt_q         <= '0;
        end else begin
            abort_o <= abort_c;
            if (abort_c) begin
                m_axis_llr_tvalid <= 1'b0;
                m_axis_llr_tlast  <= 1'b0;
                dmrs_valid_o      <= 1'b0;
                llr_cnt_q         <= '0;
            end else begin
                m_axis_llr_tvalid <= s1_data_q;
                m_axis_llr_tlast  <= s1_data_q && (llr_cnt_q == LAST_PAIR);
                dmrs_valid_o      <= s1_dmrs_q;
                if (s1_data_q) begin
                    m_axis_llr_tdata <= s1_llr_q;
                    llr_cnt_q        <= (llr_cnt_q == LAST_PAIR) ? '0 : CNTW'(llr_cnt_q + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pbch_llr_demapper.sv
// Directed bench for pbch_llr_demapper: expected pairs, DMRS strobes and
// output cycles are queued by the driver and compared after each scenario.
module tb_pbch_llr_demapper;

    logic        clk;
    logic        reset_i;
    logic [9:0]  N_id_i;
    logic        N_id_valid_i;
    logic        PBCH_start_i;
    logic [31:0] s_axis_in_tdata;
    logic        s_axis_in_tvalid;
    logic [15:0] m_axis_llr_tdata;
    logic        m_axis_llr_tvalid;
    logic        m_axis_llr_tlast;
    logic        dmrs_valid_o;
    logic        abort_o;

    pbch_llr_demapper dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .N_id_i            (N_id_i),
        .N_id_valid_i      (N_id_valid_i),
        .PBCH_start_i      (PBCH_start_i),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .m_axis_llr_tdata  (m_axis_llr_tdata),
        .m_axis_llr_tvalid (m_axis_llr_tvalid),
        .m_axis_llr_tlast  (m_axis_llr_tlast),
        .dmrs_valid_o      (dmrs_valid_o),
        .abort_o           (abort_o)
    );

    typedef struct {
        logic [15:0] data;
        int          cyc;
        bit          last;
    } pair_t;

    pair_t exp_q[$];
    pair_t act_q[$];
    int    exp_dq[$];
    int    act_dq[$];
    int    n_abort;
    int    n_stray_last;
    int    cyc;
    int    n_total;
    int    n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output event with the cycle it was observed in
    always @(negedge clk) begin
        if (m_axis_llr_tvalid) act_q.push_back('{m_axis_llr_tdata, cyc, m_axis_llr_tlast});
        else if (m_axis_llr_tlast) n_stray_last++;
        if (dmrs_valid_o) act_dq.push_back(cyc);
        if (abort_o) n_abort++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_zero();
        s_axis_in_tvalid = 1'b0;
        PBCH_start_i     = 1'b0;
        N_id_valid_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive_zero();
        end
    endtask

    task automatic set_nid(input logic [9:0] nid);
        @(posedge clk); #1;
        drive_zero();
        N_id_i       = nid;
        N_id_valid_i = 1'b1;
        @(posedge clk); #1;
        N_id_valid_i = 1'b0;
    endtask

    // Drive n_beats of an SSB; queue expected pairs (out at drive cycle + 2)
    task automatic run_ssb(input int v, input int n_beats, input bit gap, input bit kmode,
                           input logic [31:0] samp, input logic [15:0] pair, input bit expect_out,
                           input int nid_at, input logic [9:0] nid_val);
        int          npair;
        int          s;
        int          k;
        bit          disc;
        logic [15:0] ep;
        logic [31:0] d;
        npair = 0;
        if (gap) begin
            @(posedge clk); #1;
            drive_zero();
            PBCH_start_i = 1'b1;
        end
        for (int b = 0; b < n_beats; b++) begin
            @(posedge clk); #1;
            s = b / 240 + 1;
            k = b % 240;
            if (kmode) begin
                d  = {16'(k << 7), 16'(k)};
                ep = {8'(k >> 1), 8'h00};
            end else begin
                d  = samp;
                ep = pair;
            end
            s_axis_in_tdata  = d;
            s_axis_in_tvalid = 1'b1;
            PBCH_start_i     = (b == 0) && !gap;
            N_id_valid_i     = (b == nid_at);
            N_id_i           = nid_val;
            disc = (s == 2) && (k >= 48) && (k <= 191);
            if (expect_out && !disc) begin
                if (k % 4 == v) exp_dq.push_back(cyc + 2);
                else begin
                    npair++;
                    exp_q.push_back('{ep, cyc + 2, npair == 432});
                end
            end
            if (gap) begin
                @(posedge clk); #1;
                drive_zero();
            end
        end
    endtask

    task automatic check_results(input string name, input int exp_aborts);
        chk({name, "_npairs"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), act_q[i].data, exp_q[i].data);
            chk($sformatf("%s_cyc%0d", name, i), act_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s_last%0d", name, i), 32'(act_q[i].last), 32'(exp_q[i].last));
        end
        chk({name, "_ndmrs"}, act_dq.size(), exp_dq.size());
        for (int i = 0; i < exp_dq.size() && i < act_dq.size(); i++)
            chk($sformatf("%s_dmrs%0d", name, i), act_dq[i], exp_dq[i]);
        chk({name, "_aborts"}, n_abort, exp_aborts);
        chk({name, "_stray_last"}, n_stray_last, 0);
        exp_q.delete();
        act_q.delete();
        exp_dq.delete();
        act_dq.delete();
        n_abort      = 0;
        n_stray_last = 0;
    endtask

    task automatic count_lasts(output int n);
        n = 0;
        foreach (act_q[i]) if (act_q[i].last) n++;
    endtask

    initial begin
        int r;
        int nl;
        cyc = 0; n_total = 0; n_pass = 0; n_abort = 0; n_stray_last = 0;
        reset_i = 1'b1; N_id_i = '0; s_axis_in_tdata = '0;
        drive_zero();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_axis_llr_tvalid), 0);
        chk("rst_tlast", 32'(m_axis_llr_tlast), 0);
        chk("rst_tdata", 32'(m_axis_llr_tdata), 0);
        chk("rst_dmrs", 32'(dmrs_valid_o), 0);
        chk("rst_abort", 32'(abort_o), 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        idle(2);

        // No N_id yet: start must be ignored
        run_ssb(0, 720, 1'b0, 1'b0, 32'hFC00_0400, 16'hFC04, 1'b0, -1, '0);
        idle(6);
        check_results("gate", 0);

        // v=3, re=k, im=k<<7; N_id change mid-SSB must not affect this SSB
        set_nid(10'd7);
        run_ssb(3, 720, 1'b0, 1'b1, '0, '0, 1'b1, 100, 10'd0);
        idle(6);
        chk("shift_first_b0", 32'(act_q.size() > 0 ? act_q[0].data[7:0] : 8'hxx), 0);
        check_results("shift", 0);

        // Nominal: v=0 from the mid-SSB latch above
        run_ssb(0, 720, 1'b0, 1'b0, 32'hFC00_0400, 16'hFC04, 1'b1, -1, '0);
        idle(6);
        chk("nom_pairs_432", act_q.size(), 432);
        chk("nom_dmrs_144", act_dq.size(), 144);
        count_lasts(nl);
        chk("nom_one_tlast", nl, 1);
        check_results("nom", 0);

        // Saturation both directions
        run_ssb(0, 720, 1'b0, 1'b0, 32'h8000_7FFF, 16'h817F, 1'b1, -1, '0);
        idle(6);
        check_results("sat", 0);

        // Gapped: start on its own cycle, tvalid every other cycle
        run_ssb(0, 720, 1'b1, 1'b0, 32'hFC00_0400, 16'hFC04, 1'b1, -1, '0);
        idle(6);
        chk("gap_pairs_432", act_q.size(), 432);
        check_results("gap", 0);

        // Abort after 300 beats, then a full SSB
        run_ssb(0, 300, 1'b0, 1'b0, 32'hFC00_0400, 16'hFC04, 1'b1, -1, '0);
        idle(3);
        run_ssb(0, 720, 1'b0, 1'b0, 32'h0C00_F400, 16'h0CF4, 1'b1, -1, '0);
        idle(6);
        chk("abort_pairs", act_q.size(), 216 + 432);
        count_lasts(nl);
        chk("abort_one_tlast", nl, 1);
        check_results("abort", 1);

        // Reset at beat 500; everything in flight is lost
        run_ssb(0, 500, 1'b0, 1'b0, 32'hFC00_0400, 16'hFC04, 1'b1, -1, '0);
        @(posedge clk); #1;
        drive_zero();
        reset_i = 1'b1;
        r = cyc;
        while (exp_q.size() > 0 && exp_q[$].cyc > r) void'(exp_q.pop_back());
        while (exp_dq.size() > 0 && exp_dq[$] > r) void'(exp_dq.pop_back());
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_tvalid", 32'(m_axis_llr_tvalid), 0);
        chk("rst_mid_tdata", 32'(m_axis_llr_tdata), 0);
        chk("rst_mid_dmrs", 32'(dmrs_valid_o), 0);
        run_ssb(0, 720, 1'b0, 1'b0, 32'hFC00_0400, 16'hFC04, 1'b0, -1, '0);
        idle(6);
        count_lasts(nl);
        chk("rst_no_tlast", nl, 0);
        check_results("rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
